async_fifo_wptr_full: RTL and testbench

- Write-side pointer and full-flag generator for the async FIFO. Runs entirely in the write clock domain and sits directly upstream of the FIFO memory.
- Qualifies incoming write requests and drives the memory's binary write address and full flag.
- Publishes a Gray-coded write pointer for the read domain.
- Synchronizes the read domain's Gray pointer through a 2-flop synchronizer to compute full, fill level and overflow status.

---
 rtl/async_fifo_wptr_full.sv | 152 +++++++++++++++
 tb/tb_async_fifo_wptr_full.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_wptr_full.sv
// -----------------------------------------------------------------------------
// async_fifo_wptr_full
//
// Write-side pointer and full-flag generator for an asynchronous FIFO.
// Everything here runs in the write clock domain. The block qualifies write
// requests against the full flag and advances the binary write pointer that
// addresses the FIFO memory. It publishes a registered Gray-coded write pointer
// for the read domain. It also brings the read domain's Gray pointer across a
// 2-flop synchronizer to derive full, fill level and sticky overflow.
//
// Ports:
//   write_clk     in   1     write-domain clock (only clock in this block)
//   async_rst     in   1     active-low reset, sampled synchronously on write_clk
//   write_en      in   1     write request from the producer
//   rptr_gray_in  in   AW+1  Gray read pointer from the read domain (async)
//   overflow_clr  in   1     clears the sticky overflow flag
//   waddr         out  AW+1  binary write pointer; memory uses waddr[AW-1:0]
//   wptr_gray     out  AW+1  registered Gray write pointer to the read domain
//   full          out  1     registered full flag
//   wr_level      out  AW+1  write-side fill estimate, 0..DEPTH
//   overflow      out  1     sticky: a write was attempted while full
//   almost_full   out  1     only when ASYNC_FIFO_ALMOST_FULL_EN is defined
//
// Build option:
//   ASYNC_FIFO_ALMOST_FULL_EN - adds the registered almost_full output, which
//   asserts when the fill level is at or above AF_THRESHOLD.
// -----------------------------------------------------------------------------
module async_fifo_wptr_full #(
  parameter int DEPTH        = 16,
  parameter int AF_THRESHOLD = 12,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic          write_clk,
  input  logic          async_rst,
  input  logic          write_en,
  input  logic [AW:0]   rptr_gray_in,
  input  logic          overflow_clr,
  output logic [AW:0]   waddr,
  output logic [AW:0]   wptr_gray,
  output logic          full,
  output logic [AW:0]   wr_level,
  output logic          overflow
`ifdef ASYNC_FIFO_ALMOST_FULL_EN
  ,
  output logic          almost_full
`endif
);

  // Reject illegal configurations at elaboration time.
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and at least 4");
  end
  if ((AF_THRESHOLD < 1) || (AF_THRESHOLD > DEPTH)) begin : g_bad_af
    $error("AF_THRESHOLD must lie in 1..DEPTH");
  end

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [AW:0] r_wbin;
  logic [AW:0] r_wgray;
  logic [AW:0] r_rq_p1;
  logic [AW:0] r_rq_p2;
  logic        r_full;
  logic        r_overflow;

  logic        w_accept;
  logic [AW:0] w_wbin_next;
  logic [AW:0] w_wgray_next;
  logic [AW:0] w_full_gray;
  logic        w_full_next;
  logic [AW:0] w_rbin_sync;

  // Next-pointer computation; the adder wraps modulo 2^(AW+1).
  assign w_accept     = write_en & ~r_full;
  assign w_wbin_next  = r_wbin + {{AW{1'b0}}, w_accept};
  assign w_wgray_next = bin2gray(w_wbin_next);

  // Full when the write pointer is exactly one lap ahead of the synchronized
  // read pointer: in Gray code that means the top two bits are inverted.
  // Using the stale rq2 can only hold full longer, never release it early.
  assign w_full_gray  = {~r_rq_p2[AW:AW-1], r_rq_p2[AW-2:0]};
  assign w_full_next  = (w_wgray_next == w_full_gray);

  assign w_rbin_sync  = gray2bin(r_rq_p2);

  // ---- stage p1/p2: read-pointer synchronizer, pointer and flag registers ----
  always_ff @(posedge write_clk) begin
    if (!async_rst) begin
      r_wbin     <= '0;
      r_wgray    <= '0;
      r_rq_p1    <= '0;
      r_rq_p2    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_wbin     <= w_wbin_next;
      r_wgray    <= w_wgray_next;
      r_rq_p1    <= rptr_gray_in;
      r_rq_p2    <= r_rq_p1;
      r_full     <= w_full_next;
      // Set wins over clear when both happen in the same cycle.
      if (write_en && r_full) begin
        r_overflow <= 1'b1;
      end else if (overflow_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign waddr     = r_wbin;
  assign wptr_gray = r_wgray;
  assign full      = r_full;
  assign overflow  = r_overflow;
  assign wr_level  = r_wbin - w_rbin_sync;

`ifdef ASYNC_FIFO_ALMOST_FULL_EN
  localparam logic [AW:0] AF_TH = (AW+1)'(AF_THRESHOLD);

  logic        r_almost_full;
  logic [AW:0] w_rbin_sync_next;
  logic [AW:0] w_level_next;

  // Look one edge ahead so almost_full is registered yet aligned with full:
  // rq1 is the value that rq2 takes on this edge.
  assign w_rbin_sync_next = gray2bin(r_rq_p1);
  assign w_level_next     = w_wbin_next - w_rbin_sync_next;

  // ---- stage p2: almost-full flag register ----
  always_ff @(posedge write_clk) begin
    if (!async_rst) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= (w_level_next >= AF_TH);
    end
  end

  assign almost_full = r_almost_full;
`endif

endmodule

// File: tb/tb_async_fifo_wptr_full.sv
// -----------------------------------------------------------------------------
// tb_async_fifo_wptr_full
//
// Directed bench for async_fifo_wptr_full with DEPTH=16, AF_THRESHOLD=12.
// It exercises fill, overflow and clear, drain visibility, pointer wrap, and
// reset mid-operation. It also exercises almost_full when the option is built.
// -----------------------------------------------------------------------------
module tb_async_fifo_wptr_full;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          write_clk;
  logic          async_rst;
  logic          write_en;
  logic [AW:0]   rptr_gray_in;
  logic          overflow_clr;
  logic [AW:0]   waddr;
  logic [AW:0]   wptr_gray;
  logic          full;
  logic [AW:0]   wr_level;
  logic          overflow;
`ifdef ASYNC_FIFO_ALMOST_FULL_EN
  logic          almost_full;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  async_fifo_wptr_full #(
    .DEPTH        (DEPTH),
    .AF_THRESHOLD (12)
  ) dut (
    .write_clk    (write_clk),
    .async_rst    (async_rst),
    .write_en     (write_en),
    .rptr_gray_in (rptr_gray_in),
    .overflow_clr (overflow_clr),
    .waddr        (waddr),
    .wptr_gray    (wptr_gray),
    .full         (full),
    .wr_level     (wr_level),
    .overflow     (overflow)
`ifdef ASYNC_FIFO_ALMOST_FULL_EN
    ,
    .almost_full  (almost_full)
`endif
  );

  initial write_clk = 1'b0;
  always #5 write_clk = ~write_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one write_clk edge; inputs change and outputs are sampled 1ns later.
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge write_clk);
      #1;
    end
  endtask

  initial begin
    async_rst    = 1'b0;
    write_en     = 1'b0;
    rptr_gray_in = '0;
    overflow_clr = 1'b0;
    step(2);

    // Reset state
    check("rst_waddr",    32'(waddr),     32'd0);
    check("rst_wgray",    32'(wptr_gray), 32'd0);
    check("rst_full",     32'(full),      32'd0);
    check("rst_level",    32'(wr_level),  32'd0);
    check("rst_overflow", 32'(overflow),  32'd0);
    async_rst = 1'b1;

    // Fill: 16 writes with the read pointer at 0
    write_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("fill_waddr_%0d", i), 32'(waddr), 32'(i));
      step();
      check($sformatf("fill_full_%0d", i), 32'(full), (i == DEPTH - 1) ? 32'd1 : 32'd0);
    end
    write_en = 1'b0;
    check("fill_waddr_end", 32'(waddr),     32'h10);
    check("fill_wgray_end", 32'(wptr_gray), 32'h18);
    check("fill_level",     32'(wr_level),  32'd16);
    check("fill_overflow",  32'(overflow),  32'd0);

    // Overflow: two dropped writes while full
    write_en = 1'b1;
    step(2);
    write_en = 1'b0;
    check("ovf_waddr", 32'(waddr),    32'h10);
    check("ovf_set",   32'(overflow), 32'd1);
    check("ovf_full",  32'(full),     32'd1);
    overflow_clr = 1'b1;
    write_en     = 1'b1;
    step();
    write_en = 1'b0;
    check("ovf_set_wins", 32'(overflow), 32'd1);
    check("ovf_waddr2",   32'(waddr),    32'h10);
    step();
    overflow_clr = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Drain visibility: read pointer moves to binary 4
    rptr_gray_in = 5'b00110;
    step();
    check("drain_lvl_e1",  32'(wr_level), 32'd16);
    check("drain_full_e1", 32'(full),     32'd1);
    step();
    check("drain_lvl_e2",  32'(wr_level), 32'd12);
    check("drain_full_e2", 32'(full),     32'd1);
    step();
    check("drain_full_e3", 32'(full),     32'd0);
    write_en = 1'b1;
    check("drain_waddr_pre", 32'(waddr), 32'h10);
    step();
    write_en = 1'b0;
    check("drain_waddr_post", 32'(waddr),     32'h11);
    check("drain_wgray_post", 32'(wptr_gray), 32'h19);
    check("drain_level_post", 32'(wr_level),  32'd13);

    // Wrap: read pointer to binary 16, then 15 writes take wbin 17 -> 32 (=0)
    rptr_gray_in = 5'b11000;
    step(3);
    check("wrap_level_start", 32'(wr_level), 32'd1);
    check("wrap_full_start",  32'(full),     32'd0);
    write_en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      check($sformatf("wrap_full_%0d", i), 32'(full), (i == 14) ? 32'd1 : 32'd0);
    end
    write_en = 1'b0;
    check("wrap_waddr", 32'(waddr),     32'd0);
    check("wrap_wgray", 32'(wptr_gray), 32'd0);
    check("wrap_level", 32'(wr_level),  32'd16);

    // Empty again, then write up to waddr 7
    rptr_gray_in = 5'b00000;
    step(3);
    check("empty_full",  32'(full),     32'd0);
    check("empty_level", 32'(wr_level), 32'd0);
    write_en = 1'b1;
    step(7);
    check("pre_rst_waddr", 32'(waddr), 32'd7);
    check("pre_rst_wgray", 32'(wptr_gray), 32'h4);

    // Reset mid-operation with write_en held high
    async_rst = 1'b0;
    step();
    check("midrst_waddr",    32'(waddr),     32'd0);
    check("midrst_wgray",    32'(wptr_gray), 32'd0);
    check("midrst_full",     32'(full),      32'd0);
    check("midrst_level",    32'(wr_level),  32'd0);
    check("midrst_overflow", 32'(overflow),  32'd0);
    async_rst = 1'b1;
    step();
    write_en = 1'b0;
    check("post_rst_waddr", 32'(waddr), 32'd1);

    // Almost-full threshold from a clean reset
    async_rst = 1'b0;
    step();
    async_rst = 1'b1;
    write_en  = 1'b1;
    step(11);
    check("af_level_11", 32'(wr_level), 32'd11);
`ifdef ASYNC_FIFO_ALMOST_FULL_EN
    check("af_11", 32'(almost_full), 32'd0);
`endif
    step();
    write_en = 1'b0;
    check("af_level_12", 32'(wr_level), 32'd12);
    check("af_full_12",  32'(full),     32'd0);
`ifdef ASYNC_FIFO_ALMOST_FULL_EN
    check("af_12", 32'(almost_full), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
